dbg_display_scan: RTL and testbench

Parametrised debug display controller for the pipelined MIPS core's FPGA board. It selects one of N_CH 32-bit probe buses (PC, instruction, ALU result, forwarding/hazard state, ...) and snapshots it into a shadow register. It then time-multiplexes the value onto an N_DIG-digit active-low seven-segment display, paging automatically through words wider than the display. It replaces the fixed 4-digit, fixed-select display path with one configurable scan engine that adds hold/capture and page rotation.

---
 rtl/dbg_display_scan.sv | 190 +++++++++++++++++++
 tb/tb_dbg_display_scan.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_display_scan.sv
// dbg_display_scan
//   Debug display scan engine for the pipelined MIPS board. Picks one of N_CH
//   probe buses, snapshots it into a shadow register (with hold/capture), and
//   time-multiplexes it onto an N_DIG-digit active-low seven-segment display.
//   Words wider than the display are shown a page at a time, rotating
//   automatically.
//
//   Optional feature: define DISP_BLANK_EN to blank leading-zero digits across
//   the whole word (nibble 0 always shown).
//
// Ports
//   clk1     in   system clock, all state on the rising edge
//   rst      in   synchronous active-high reset
//   ch_data  in   packed probes, channel k = ch_data[k*DATA_W +: DATA_W]
//   sel      in   channel select; values >= N_CH show dashes
//   hold     in   1 = freeze shadow register (dp on digit 0 lit)
//   capture  in   one-cycle pulse reloading the shadow while hold=1
//   anodes   out  active-low digit enables, bit 0 = least-significant digit
//   cathods  out  active-low segments, [7]=dp, [6:0]=g..a
//   page     out  page currently displayed, 0 = least-significant nibbles

module dbg_display_scan #(
  parameter  int N_CH       = 8,
  parameter  int DATA_W     = 32,
  parameter  int N_DIG      = 4,
  parameter  int SCAN_DIV   = 16,
  parameter  int PAGE_SCANS = 256,
  localparam int SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int N_PG       = DATA_W / (4 * N_DIG),
  localparam int PG_W       = (N_PG > 1) ? $clog2(N_PG) : 1
) (
  input  logic                     clk1,
  input  logic                     rst,
  input  logic [N_CH*DATA_W-1:0]   ch_data,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     hold,
  input  logic                     capture,
  output logic [N_DIG-1:0]         anodes,
  output logic [7:0]               cathods,
  output logic [PG_W-1:0]          page
);

  localparam int N_NIB  = DATA_W / 4;
  localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DIG_W  = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int SCAN_W = (PAGE_SCANS > 1) ? $clog2(PAGE_SCANS) : 1;

  logic [DATA_W-1:0] shadow;
  logic              shadow_valid;
  logic [SEL_W-1:0]  sel_q;
  logic [DATA_W-1:0] sel_data;
  logic              sel_ok;
  logic              sel_changed;

  logic [DIV_W-1:0]  div_cnt;
  logic [DIG_W-1:0]  dig_cnt;
  logic [SCAN_W-1:0] scan_cnt;
  logic [PG_W-1:0]   pg_cnt;

  int                nib_idx;
  logic [3:0]        nib;
  logic              blank;
  logic [N_DIG-1:0]  anodes_d;
  logic              dp_n;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Channel mux and range check; the extra bit keeps N_CH representable
  // when N_CH is a power of two.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (SEL_W'(k) == sel) sel_data = ch_data[k*DATA_W +: DATA_W];
    end
  end

  assign sel_ok      = ({1'b0, sel} < (SEL_W+1)'(N_CH));
  assign sel_changed = (sel != sel_q);

  // sel_q is loaded from sel during reset so that leaving reset never looks
  // like a select change.
  always_ff @(posedge clk1) begin
    if (rst) begin
      shadow       <= '0;
      shadow_valid <= 1'b1;
      sel_q        <= sel;
    end else begin
      sel_q        <= sel;
      shadow_valid <= sel_ok;
      if (sel_ok && (!hold || capture)) shadow <= sel_data;
    end
  end

  // Scan timing: div -> dig -> scan -> page. A select change restarts the
  // whole sequence so a new channel always starts on page 0, digit 0.
  always_ff @(posedge clk1) begin
    if (rst || sel_changed) begin
      div_cnt  <= '0;
      dig_cnt  <= '0;
      scan_cnt <= '0;
      pg_cnt   <= '0;
    end else if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
      div_cnt <= '0;
      if (dig_cnt == DIG_W'(N_DIG - 1)) begin
        dig_cnt <= '0;
        if (scan_cnt == SCAN_W'(PAGE_SCANS - 1)) begin
          scan_cnt <= '0;
          if (pg_cnt == PG_W'(N_PG - 1)) pg_cnt <= '0;
          else                           pg_cnt <= pg_cnt + 1'b1;
        end else begin
          scan_cnt <= scan_cnt + 1'b1;
        end
      end else begin
        dig_cnt <= dig_cnt + 1'b1;
      end
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_comb begin
    nib_idx = int'(pg_cnt) * N_DIG + int'(dig_cnt);
    nib     = 4'h0;
    for (int i = 0; i < N_NIB; i++) begin
      if (i == nib_idx) nib = shadow[4*i +: 4];
    end
  end

`ifdef DISP_BLANK_EN
  int hi_nib;

  // Highest non-zero nibble; stays 0 for an all-zero word so nibble 0 is
  // always shown.
  always_comb begin
    hi_nib = 0;
    for (int i = 0; i < N_NIB; i++) begin
      if (shadow[4*i +: 4] != 4'h0) hi_nib = i;
    end
  end

  assign blank = (nib_idx > hi_nib);
`else
  assign blank = 1'b0;
`endif

  assign anodes_d = ~(N_DIG'(1) << dig_cnt);
  assign dp_n     = !(hold && (dig_cnt == '0));

  always_ff @(posedge clk1) begin
    if (rst) begin
      anodes  <= '1;
      cathods <= 8'hFF;
      page    <= '0;
    end else begin
      page <= pg_cnt;
      if (!shadow_valid) begin
        anodes  <= anodes_d;
        cathods <= 8'hBF;
      end else if (blank) begin
        anodes  <= '1;
        cathods <= 8'hFF;
      end else begin
        anodes  <= anodes_d;
        cathods <= {dp_n, hex7(nib)};
      end
    end
  end

endmodule

// File: tb/tb_dbg_display_scan.sv
// Self-checking bench for dbg_display_scan: randomized and directed stimulus
// against a time-based behavioural model (digit/page derived from elapsed
// cycles since the last restart).

module tb_dbg_display_scan;

  localparam int N_CH       = 6;
  localparam int DATA_W     = 32;
  localparam int N_DIG      = 4;
  localparam int SCAN_DIV   = 4;
  localparam int PAGE_SCANS = 2;
  localparam int N_PG       = DATA_W / (4 * N_DIG);
  localparam int PAGE_LEN   = SCAN_DIV * N_DIG * PAGE_SCANS;

`ifdef DISP_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic                   clk1 = 1'b0;
  logic                   rst;
  logic [N_CH*DATA_W-1:0] ch_data;
  logic [2:0]             sel;
  logic                   hold;
  logic                   capture;
  logic [N_DIG-1:0]       anodes;
  logic [7:0]             cathods;
  logic [0:0]             page;

  logic [31:0] ch [N_CH];

  dbg_display_scan #(
    .N_CH(N_CH), .DATA_W(DATA_W), .N_DIG(N_DIG),
    .SCAN_DIV(SCAN_DIV), .PAGE_SCANS(PAGE_SCANS)
  ) dut (
    .clk1(clk1), .rst(rst), .ch_data(ch_data), .sel(sel), .hold(hold),
    .capture(capture), .anodes(anodes), .cathods(cathods), .page(page)
  );

  always #5 clk1 = ~clk1;

  always_comb begin
    for (int k = 0; k < N_CH; k++) ch_data[k*DATA_W +: DATA_W] = ch[k];
  end

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          m_t;
  logic [31:0] m_sh;
  logic        m_valid;
  logic [2:0]  m_psel;
  logic [3:0]  exp_an;
  logic [7:0]  exp_cat;
  logic [0:0]  exp_pg;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic model_step();
    int dg, pg, ni, hi;
    logic [3:0] n;
    if (rst) begin
      exp_an = 4'hF; exp_cat = 8'hFF; exp_pg = 1'b0;
      m_t = 0; m_sh = '0; m_valid = 1'b1; m_psel = sel;
    end else begin
      dg = (m_t / SCAN_DIV) % N_DIG;
      pg = (m_t / PAGE_LEN) % N_PG;
      ni = pg * N_DIG + dg;
      hi = 0;
      for (int i = 0; i < 8; i++) if (((m_sh >> (4*i)) & 32'hF) != 0) hi = i;
      n = 4'((m_sh >> (4*ni)) & 32'hF);
      exp_pg = 1'(pg);
      if (!m_valid) begin
        exp_an = ~(4'b1 << dg); exp_cat = 8'hBF;
      end else if (BLANK && ni > hi) begin
        exp_an = 4'hF; exp_cat = 8'hFF;
      end else begin
        exp_an = ~(4'b1 << dg);
        exp_cat = {~(hold && dg == 0), seg_tab[n]};
      end
      m_t = (sel != m_psel) ? 0 : m_t + 1;
      m_psel = sel;
      m_valid = (sel < N_CH);
      if (m_valid && (!hold || capture)) m_sh = ch[sel];
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    sel = 3'd1; hold = 1'b0; capture = 1'b0;
    for (int k = 0; k < N_CH; k++) ch[k] = '0;
    ch[1] = 32'h1234ABCD;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if ({anodes, cathods, page} !== {4'hF, 8'hFF, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got an=%h cat=%h pg=%h, want an=f cat=ff pg=0", anodes, cathods, page);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (anodes !== 4'b1110) begin
      errors++;
      $display("FAIL reset_release_digit0: got an=%b, want 1110", anodes);
    end
  endtask

  task automatic test_paging();
    for (int i = 0; i < 80; i++) begin
      tick();
      checks++;
      if ({anodes, cathods, page} !== {exp_an, exp_cat, exp_pg}) begin
        errors++;
        $display("FAIL paging[%0d]: got an=%h cat=%h pg=%h, want an=%h cat=%h pg=%h",
                 i, anodes, cathods, page, exp_an, exp_cat, exp_pg);
      end
    end
  endtask

  task automatic test_hold_capture();
    hold = 1'b1;
    tick();
    ch[1] = 32'hFFFFFFFF;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if ({anodes, cathods, page} !== {exp_an, exp_cat, exp_pg}) begin
        errors++;
        $display("FAIL hold[%0d]: got an=%h cat=%h pg=%h, want an=%h cat=%h pg=%h",
                 i, anodes, cathods, page, exp_an, exp_cat, exp_pg);
      end
    end
    capture = 1'b1;
    tick();
    capture = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if ({anodes, cathods, page} !== {exp_an, exp_cat, exp_pg}) begin
        errors++;
        $display("FAIL capture[%0d]: got an=%h cat=%h pg=%h, want an=%h cat=%h pg=%h",
                 i, anodes, cathods, page, exp_an, exp_cat, exp_pg);
      end
    end
    hold = 1'b0;
  endtask

  task automatic test_invalid_select();
    sel = 3'd7;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({anodes, cathods, page} !== {exp_an, exp_cat, exp_pg}) begin
        errors++;
        $display("FAIL invalid_sel[%0d]: got an=%h cat=%h pg=%h, want an=%h cat=%h pg=%h",
                 i, anodes, cathods, page, exp_an, exp_cat, exp_pg);
      end
    end
    ch[0] = $urandom;
    sel = 3'd0;
    tick();
    tick();
    checks++;
    if ({anodes, page} !== {4'b1110, 1'b0}) begin
      errors++;
      $display("FAIL sel_restart: got an=%b pg=%h, want an=1110 pg=0", anodes, page);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({anodes, cathods, page} !== {exp_an, exp_cat, exp_pg}) begin
        errors++;
        $display("FAIL sel_back[%0d]: got an=%h cat=%h pg=%h, want an=%h cat=%h pg=%h",
                 i, anodes, cathods, page, exp_an, exp_cat, exp_pg);
      end
    end
  endtask

  task automatic test_blanking();
    logic [31:0] pats [3] = '{32'h00000012, 32'h00000000, 32'h00F00000};
    for (int p = 0; p < 3; p++) begin
      ch[0] = pats[p];
      for (int i = 0; i < 70; i++) begin
        tick();
        checks++;
        if ({anodes, cathods, page} !== {exp_an, exp_cat, exp_pg}) begin
          errors++;
          $display("FAIL blank_%0d[%0d]: got an=%h cat=%h pg=%h, want an=%h cat=%h pg=%h",
                   p, i, anodes, cathods, page, exp_an, exp_cat, exp_pg);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) hold = ~hold;
      capture = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0)
        ch[$urandom_range(0, N_CH-1)] = $urandom >> $urandom_range(0, 31);
      tick();
      checks++;
      if ({anodes, cathods, page} !== {exp_an, exp_cat, exp_pg}) begin
        errors++;
        $display("FAIL random[%0d]: got an=%h cat=%h pg=%h, want an=%h cat=%h pg=%h",
                 i, anodes, cathods, page, exp_an, exp_cat, exp_pg);
      end
    end
    capture = 1'b0;
    hold = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    int budget;
    sel = 3'd2;
    ch[2] = 32'h89ABCDEF;
    tick();
    budget = 0;
    while (!(((m_t / PAGE_LEN) % N_PG == 1) && ((m_t / SCAN_DIV) % N_DIG == 2)) && budget < 200) begin
      tick();
      budget++;
    end
    checks++;
    if (budget >= 200) begin
      errors++;
      $display("FAIL mid_scan_reach: waited %0d cycles, want < 200", budget);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({anodes, cathods, page} !== {4'hF, 8'hFF, 1'b0}) begin
      errors++;
      $display("FAIL mid_scan_reset: got an=%h cat=%h pg=%h, want an=f cat=ff pg=0", anodes, cathods, page);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({anodes, page} !== {4'b1110, 1'b0}) begin
      errors++;
      $display("FAIL mid_scan_resume: got an=%b pg=%h, want an=1110 pg=0", anodes, page);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if ({anodes, cathods, page} !== {exp_an, exp_cat, exp_pg}) begin
        errors++;
        $display("FAIL after_reset[%0d]: got an=%h cat=%h pg=%h, want an=%h cat=%h pg=%h",
                 i, anodes, cathods, page, exp_an, exp_cat, exp_pg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_paging();
    test_hold_capture();
    test_invalid_select();
    test_blanking();
    test_random();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
